vc_wrr_scheduler: RTL and testbench

- Weighted round-robin scheduler that drains the two virtual-channel FIFOs (VC0, VC1) into the shared VC-to-destination mux/demux path.
- Sits between the VC FIFOs and the D0/D1 demux. Decides each cycle which VC, if any, to pop.
- Honours per-destination backpressure from the D0/D1 FIFO pause flags.
- Also provides an idle indication and per-VC grant counters for the control FSM.

---
 rtl/vc_wrr_scheduler_pkg.sv | 27 ++
 rtl/vc_wrr_scheduler_wrr_grant_logic.sv | 84 ++++++++
 rtl/vc_wrr_scheduler.sv | 119 +++++++++++
 tb/tb_vc_wrr_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_wrr_scheduler_pkg.sv
// Shared definitions for the VC scheduler slice: serve-state encoding,
// destination constants and the datapath word geometry used by the VC FIFOs,
// the VC mux and the D0/D1 demux.
package vc_wrr_scheduler_pkg;

  // Datapath word geometry shared across the slice.
  localparam int VC_DATA_W   = 6;
  localparam int VC_DEST_BIT = 4;
  localparam int VC_WEIGHT_W = 3;
  localparam int VC_CNT_W    = 8;

  // Destination encoding of the word's destination bit.
  localparam logic DEST_D0 = 1'b0;
  localparam logic DEST_D1 = 1'b1;

  // Which VC currently owns the turn; the encoding doubles as the VC index.
  typedef enum logic {
    SERVE_VC0 = 1'b0,
    SERVE_VC1 = 1'b1
  } serve_e;

  // The VC that is not s.
  function automatic serve_e other_vc(input serve_e s);
    return (s == SERVE_VC0) ? SERVE_VC1 : SERVE_VC0;
  endfunction

endpackage

// File: rtl/vc_wrr_scheduler_wrr_grant_logic.sv
// Combinational core of the weighted round-robin scheduler: per-VC
// eligibility (empty, enable, destination backpressure), the work-conserving
// grant choice, and the next turn owner / run length.
module wrr_grant_logic
  import vc_wrr_scheduler_pkg::*;
#(
  parameter int WEIGHT_W = VC_WEIGHT_W
) (
  input  logic                i_enable,
  input  logic                i_vc0_empty,
  input  logic                i_vc1_empty,
  input  logic                i_vc0_dest,
  input  logic                i_vc1_dest,
  input  logic                i_d0_pause,
  input  logic                i_d1_pause,
  input  logic [WEIGHT_W-1:0] i_weight_vc0,
  input  logic [WEIGHT_W-1:0] i_weight_vc1,
  input  serve_e              i_cur,
  input  logic [WEIGHT_W-1:0] i_cnt,
  output logic                o_grant,
  output serve_e              o_grant_vc,
  output serve_e              o_next_cur,
  output logic [WEIGHT_W-1:0] o_next_cnt
);

  localparam logic [WEIGHT_W-1:0] ONE = {{(WEIGHT_W-1){1'b0}}, 1'b1};

  logic                w_pause_vc0;
  logic                w_pause_vc1;
  logic                w_elig_vc0;
  logic                w_elig_vc1;
  logic [WEIGHT_W-1:0] w_weff_vc0;
  logic [WEIGHT_W-1:0] w_weff_vc1;
  logic                w_elig_cur;
  logic                w_elig_other;
  logic [WEIGHT_W:0]   w_run;
  logic [WEIGHT_W-1:0] w_weff_sel;

  // Each VC is held off by the pause flag of the FIFO its head word targets.
  assign w_pause_vc0 = (i_vc0_dest == DEST_D1) ? i_d1_pause : i_d0_pause;
  assign w_pause_vc1 = (i_vc1_dest == DEST_D1) ? i_d1_pause : i_d0_pause;
  assign w_elig_vc0  = i_enable & ~i_vc0_empty & ~w_pause_vc0;
  assign w_elig_vc1  = i_enable & ~i_vc1_empty & ~w_pause_vc1;

  // A zero weight still grants one word per turn so a VC is never starved.
  assign w_weff_vc0 = (i_weight_vc0 == '0) ? ONE : i_weight_vc0;
  assign w_weff_vc1 = (i_weight_vc1 == '0) ? ONE : i_weight_vc1;

  assign w_elig_cur   = (i_cur == SERVE_VC0) ? w_elig_vc0 : w_elig_vc1;
  assign w_elig_other = (i_cur == SERVE_VC0) ? w_elig_vc1 : w_elig_vc0;

  // Grant select and turn/run update; holding state is the default.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    o_grant    = 1'b0;
    o_grant_vc = i_cur;
    o_next_cur = i_cur;
    o_next_cnt = i_cnt;
    w_run      = '0;
    w_weff_sel = w_weff_vc0;

    if (w_elig_cur) begin
      o_grant    = 1'b1;
      o_grant_vc = i_cur;
    end else if (w_elig_other) begin
      o_grant    = 1'b1;
      o_grant_vc = other_vc(i_cur);
    end

    if (o_grant) begin
      // A grant to the non-owner starts a fresh run of length one.
      w_run      = (o_grant_vc == i_cur) ? ({1'b0, i_cnt} + 1'b1) : {1'b0, ONE};
      w_weff_sel = (o_grant_vc == SERVE_VC1) ? w_weff_vc1 : w_weff_vc0;
      if (w_run >= {1'b0, w_weff_sel}) begin
        o_next_cur = other_vc(o_grant_vc);
        o_next_cnt = '0;
      end else begin
        o_next_cur = o_grant_vc;
        o_next_cnt = w_run[WEIGHT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/vc_wrr_scheduler.sv
// Weighted round-robin scheduler draining VC0/VC1 into the shared D0/D1 path.
// Pops are combinational from the current head words; the popped word is
// registered and presented to the demux one cycle later.
module vc_wrr_scheduler
  import vc_wrr_scheduler_pkg::*;
#(
  parameter int DATA_W   = VC_DATA_W,
  parameter int DEST_BIT = VC_DEST_BIT,
  parameter int WEIGHT_W = VC_WEIGHT_W,
  parameter int CNT_W    = VC_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [WEIGHT_W-1:0] weight_vc0,
  input  logic [WEIGHT_W-1:0] weight_vc1,
  input  logic                vc0_empty,
  input  logic                vc1_empty,
  input  logic [DATA_W-1:0]   vc0_head,
  input  logic [DATA_W-1:0]   vc1_head,
  input  logic                d0_pause,
  input  logic                d1_pause,
  output logic                pop_vc0,
  output logic                pop_vc1,
  output logic [DATA_W-1:0]   data_out,
  output logic                valid_out,
  output logic                grant_vc,
  output logic                idle,
  output logic [CNT_W-1:0]    grants_vc0,
  output logic [CNT_W-1:0]    grants_vc1
);

  serve_e              r_cur;
  logic [WEIGHT_W-1:0] r_cnt;
  logic [DATA_W-1:0]   r_data;
  logic                r_valid;
  serve_e              r_grant_vc;
  logic [CNT_W-1:0]    r_grants_vc0;
  logic [CNT_W-1:0]    r_grants_vc1;

  logic                w_grant;
  serve_e              w_grant_vc;
  serve_e              w_next_cur;
  logic [WEIGHT_W-1:0] w_next_cnt;
  logic                w_sched_en;

  // Reset suppresses pops in the same cycle, not just from the next edge.
  assign w_sched_en = enable & ~reset;

  wrr_grant_logic #(
    .WEIGHT_W (WEIGHT_W)
  ) u_grant (
    .i_enable     (w_sched_en),
    .i_vc0_empty  (vc0_empty),
    .i_vc1_empty  (vc1_empty),
    .i_vc0_dest   (vc0_head[DEST_BIT]),
    .i_vc1_dest   (vc1_head[DEST_BIT]),
    .i_d0_pause   (d0_pause),
    .i_d1_pause   (d1_pause),
    .i_weight_vc0 (weight_vc0),
    .i_weight_vc1 (weight_vc1),
    .i_cur        (r_cur),
    .i_cnt        (r_cnt),
    .o_grant      (w_grant),
    .o_grant_vc   (w_grant_vc),
    .o_next_cur   (w_next_cur),
    .o_next_cnt   (w_next_cnt)
  );

  assign pop_vc0 = w_grant & (w_grant_vc == SERVE_VC0);
  assign pop_vc1 = w_grant & (w_grant_vc == SERVE_VC1);

  // Turn owner and run length; they only move when something is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      r_cur <= SERVE_VC0;
      r_cnt <= '0;
    end else if (w_grant) begin
      r_cur <= w_next_cur;
      r_cnt <= w_next_cnt;
    end
  end

  // Output word register; the in-flight word is dropped on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the data register is reset too because downstream sees data_out = 0 after reset.
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_grant_vc <= SERVE_VC0;
    end else begin
      r_valid <= w_grant;
      if (w_grant) begin
        r_data     <= (w_grant_vc == SERVE_VC1) ? vc1_head : vc0_head;
        r_grant_vc <= w_grant_vc;
      end
    end
  end

  // Wrapping per-VC grant counters for the control FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grants_vc0 <= '0;
      r_grants_vc1 <= '0;
    end else begin
      if (pop_vc0) r_grants_vc0 <= r_grants_vc0 + 1'b1;
      if (pop_vc1) r_grants_vc1 <= r_grants_vc1 + 1'b1;
    end
  end

  assign data_out   = r_data;
  assign valid_out  = r_valid;
  assign grant_vc   = r_grant_vc;
  assign grants_vc0 = r_grants_vc0;
  assign grants_vc1 = r_grants_vc1;
  assign idle       = vc0_empty & vc1_empty & ~r_valid;

endmodule

// File: tb/tb_vc_wrr_scheduler.sv
// Directed bench for vc_wrr_scheduler: models the VC FIFOs and D FIFO fill
// levels with queues/counters and checks pop order, output timing, counters,
// backpressure and reset behaviour against hand-computed expectations.
module tb_vc_wrr_scheduler;

  localparam int D_DEPTH = 4;
  localparam int D_THR   = D_DEPTH - 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] weight_vc0, weight_vc1;
  logic       vc0_empty, vc1_empty;
  logic [5:0] vc0_head, vc1_head;
  logic       d0_pause, d1_pause;
  logic       pop_vc0, pop_vc1;
  logic [5:0] data_out;
  logic       valid_out;
  logic       grant_vc;
  logic       idle;
  logic [7:0] grants_vc0, grants_vc1;

  logic [5:0] q0[$];
  logic [5:0] q1[$];
  logic       man_d0_pause, man_d1_pause;
  logic       auto_pause;
  int         d_cnt[2];
  int         d_max;
  int         total = 0;
  int         bad   = 0;

  vc_wrr_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .weight_vc0 (weight_vc0),
    .weight_vc1 (weight_vc1),
    .vc0_empty  (vc0_empty),
    .vc1_empty  (vc1_empty),
    .vc0_head   (vc0_head),
    .vc1_head   (vc1_head),
    .d0_pause   (d0_pause),
    .d1_pause   (d1_pause),
    .pop_vc0    (pop_vc0),
    .pop_vc1    (pop_vc1),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .grant_vc   (grant_vc),
    .idle       (idle),
    .grants_vc0 (grants_vc0),
    .grants_vc1 (grants_vc1)
  );

  always #5 clk = ~clk;

  task automatic drive_fifos();
    vc0_empty = (q0.size() == 0);
    vc1_empty = (q1.size() == 0);
    vc0_head  = vc0_empty ? 6'h00 : q0[0];
    vc1_head  = vc1_empty ? 6'h00 : q1[0];
    d0_pause  = man_d0_pause | (auto_pause && d_cnt[0] >= D_THR);
    d1_pause  = man_d1_pause | (auto_pause && d_cnt[1] >= D_THR);
  endtask

  // One clock: sample pops and the outgoing word, then apply them to the models.
  task automatic step();
    logic       p0, p1, v;
    logic [5:0] d;
    #1;
    p0 = pop_vc0; p1 = pop_vc1; v = valid_out; d = data_out;
    total++; if (p0 && p1) begin bad++; $display("FAIL dual_pop got=%b%b exp=one-hot", p0, p1); end
    @(posedge clk);
    #1;
    if (p0 && q0.size() > 0) void'(q0.pop_front());
    if (p1 && q1.size() > 0) void'(q1.pop_front());
    if (v) begin
      d_cnt[int'(d[4])]++;
      if (d_cnt[int'(d[4])] > d_max) d_max = d_cnt[int'(d[4])];
    end
    drive_fifos();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1;
    q0.delete(); q1.delete();
    d_cnt[0] = 0; d_cnt[1] = 0; d_max = 0;
    man_d0_pause = 1'b0; man_d1_pause = 1'b0; auto_pause = 1'b0;
    drive_fifos();
    step(); step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; weight_vc0 = 3'd3; weight_vc1 = 3'd1;
    q0.delete(); q1.delete();
    q0.push_back(6'h01); q0.push_back(6'h02);
    q1.push_back(6'h21); q1.push_back(6'h22);
    drive_fifos();
    step(); step();
    total++; if (pop_vc0 !== 1'b0) begin bad++; $display("FAIL rst_pop0 got=%b exp=0", pop_vc0); end
    total++; if (pop_vc1 !== 1'b0) begin bad++; $display("FAIL rst_pop1 got=%b exp=0", pop_vc1); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", valid_out); end
    total++; if (data_out !== 6'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", data_out); end
    total++; if (grant_vc !== 1'b0) begin bad++; $display("FAIL rst_grant_vc got=%b exp=0", grant_vc); end
    total++; if (grants_vc0 !== 8'd0) begin bad++; $display("FAIL rst_cnt0 got=%0d exp=0", grants_vc0); end
    total++; if (grants_vc1 !== 8'd0) begin bad++; $display("FAIL rst_cnt1 got=%0d exp=0", grants_vc1); end
    total++; if (idle !== 1'b0) begin bad++; $display("FAIL rst_idle got=%b exp=0", idle); end
    reset = 1'b0;
    #1;
    total++; if (pop_vc0 !== 1'b1) begin bad++; $display("FAIL first_pop0 got=%b exp=1", pop_vc0); end
    total++; if (pop_vc1 !== 1'b0) begin bad++; $display("FAIL first_pop1 got=%b exp=0", pop_vc1); end
    step();
    total++; if (data_out !== 6'h01) begin bad++; $display("FAIL first_data got=%h exp=01", data_out); end
    // Empty FIFOs after a reset must read as idle.
    do_reset();
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL rst_idle_empty got=%b exp=1", idle); end
  endtask

  // Runs n grants with both VCs loaded and checks order against the bit pattern (1 = VC1).
  task automatic run_order(input int n, input logic [7:0] order, input string tag);
    logic       eg;
    logic [5:0] ew;
    for (int i = 0; i < n; i++) begin
      eg = order[i];
      ew = eg ? q1[0] : q0[0];
      total++; if (pop_vc0 !== ~eg) begin bad++; $display("FAIL %s_pop0[%0d] got=%b exp=%b", tag, i, pop_vc0, ~eg); end
      total++; if (pop_vc1 !== eg) begin bad++; $display("FAIL %s_pop1[%0d] got=%b exp=%b", tag, i, pop_vc1, eg); end
      step();
      total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL %s_valid[%0d] got=%b exp=1", tag, i, valid_out); end
      total++; if (data_out !== ew) begin bad++; $display("FAIL %s_data[%0d] got=%h exp=%h", tag, i, data_out, ew); end
      total++; if (grant_vc !== eg) begin bad++; $display("FAIL %s_gvc[%0d] got=%b exp=%b", tag, i, grant_vc, eg); end
    end
  endtask

  task automatic test_weights_3_1();
    do_reset();
    weight_vc0 = 3'd3; weight_vc1 = 3'd1;
    for (int i = 0; i < 8; i++) begin
      q0.push_back(6'(i)); q1.push_back(6'(6'h20 + i));
    end
    drive_fifos(); #1;
    run_order(8, 8'b1000_1000, "w31");
    total++; if (grants_vc0 !== 8'd6) begin bad++; $display("FAIL w31_cnt0 got=%0d exp=6", grants_vc0); end
    total++; if (grants_vc1 !== 8'd2) begin bad++; $display("FAIL w31_cnt1 got=%0d exp=2", grants_vc1); end
  endtask

  task automatic test_work_conserving();
    logic [5:0] ew;
    do_reset();
    weight_vc0 = 3'd2; weight_vc1 = 3'd2;
    for (int i = 0; i < 4; i++) q1.push_back(6'(6'h28 + i));
    drive_fifos(); #1;
    for (int i = 0; i < 4; i++) begin
      ew = q1[0];
      total++; if (pop_vc1 !== 1'b1 || pop_vc0 !== 1'b0) begin bad++; $display("FAIL wc_pop[%0d] got=%b%b exp=01", i, pop_vc0, pop_vc1); end
      step();
      total++; if (data_out !== ew || grant_vc !== 1'b1) begin bad++; $display("FAIL wc_data[%0d] got=%h/%b exp=%h/1", i, data_out, grant_vc, ew); end
    end
    total++; if (idle !== 1'b0) begin bad++; $display("FAIL wc_idle_busy got=%b exp=0", idle); end
    step();
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL wc_valid_end got=%b exp=0", valid_out); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL wc_idle got=%b exp=1", idle); end
    total++; if (data_out !== 6'h2B) begin bad++; $display("FAIL wc_data_hold got=%h exp=2b", data_out); end
  endtask

  task automatic test_backpressure();
    do_reset();
    weight_vc0 = 3'd1; weight_vc1 = 3'd1;
    man_d1_pause = 1'b1;
    q0.push_back(6'h10); q0.push_back(6'h11);
    q1.push_back(6'h03); q1.push_back(6'h04);
    drive_fifos(); #1;
    for (int i = 0; i < 2; i++) begin
      total++; if (pop_vc0 !== 1'b0 || pop_vc1 !== 1'b1) begin bad++; $display("FAIL bp_pop[%0d] got=%b%b exp=01", i, pop_vc0, pop_vc1); end
      step();
    end
    total++; if (pop_vc0 !== 1'b0 || pop_vc1 !== 1'b0) begin bad++; $display("FAIL bp_stall got=%b%b exp=00", pop_vc0, pop_vc1); end
    total++; if (idle !== 1'b0) begin bad++; $display("FAIL bp_idle got=%b exp=0", idle); end
    man_d1_pause = 1'b0;
    drive_fifos(); #1;
    total++; if (pop_vc0 !== 1'b1 || pop_vc1 !== 1'b0) begin bad++; $display("FAIL bp_release got=%b%b exp=10", pop_vc0, pop_vc1); end
    step();
    total++; if (data_out !== 6'h10 || grant_vc !== 1'b0) begin bad++; $display("FAIL bp_data got=%h/%b exp=10/0", data_out, grant_vc); end
  endtask

  task automatic test_dfifo_margin();
    int npops;
    do_reset();
    weight_vc0 = 3'd1; weight_vc1 = 3'd1;
    auto_pause = 1'b1;
    for (int i = 0; i < 8; i++) q0.push_back(6'(i));
    drive_fifos(); #1;
    npops = 0;
    for (int i = 0; i < 8; i++) begin
      if (pop_vc0) npops++;
      step();
    end
    total++; if (npops != 3) begin bad++; $display("FAIL dm_pops got=%0d exp=3", npops); end
    total++; if (d_cnt[0] != 3) begin bad++; $display("FAIL dm_fill got=%0d exp=3", d_cnt[0]); end
    total++; if (d_max > D_DEPTH) begin bad++; $display("FAIL dm_overflow got=%0d exp<=%0d", d_max, D_DEPTH); end
    total++; if (grants_vc0 !== 8'd3) begin bad++; $display("FAIL dm_cnt0 got=%0d exp=3", grants_vc0); end
  endtask

  task automatic test_enable_drop();
    do_reset();
    weight_vc0 = 3'd1; weight_vc1 = 3'd1;
    for (int i = 0; i < 4; i++) begin
      q0.push_back(6'(6'h05 + i)); q1.push_back(6'(6'h25 + i));
    end
    drive_fifos(); #1;
    step(); step();
    enable = 1'b0;
    #1;
    total++; if (pop_vc0 !== 1'b0 || pop_vc1 !== 1'b0) begin bad++; $display("FAIL en_pop got=%b%b exp=00", pop_vc0, pop_vc1); end
    total++; if (valid_out !== 1'b1 || data_out !== 6'h25) begin bad++; $display("FAIL en_last got=%b/%h exp=1/25", valid_out, data_out); end
    step();
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL en_valid got=%b exp=0", valid_out); end
    total++; if (data_out !== 6'h25) begin bad++; $display("FAIL en_hold got=%h exp=25", data_out); end
    enable = 1'b1;
    #1;
    total++; if (pop_vc0 !== 1'b1) begin bad++; $display("FAIL en_resume got=%b exp=1", pop_vc0); end
    step();
    total++; if (data_out !== 6'h06 || valid_out !== 1'b1) begin bad++; $display("FAIL en_resume_data got=%h/%b exp=06/1", data_out, valid_out); end
    total++; if (grants_vc0 !== 8'd2 || grants_vc1 !== 8'd1) begin bad++; $display("FAIL en_cnt got=%0d/%0d exp=2/1", grants_vc0, grants_vc1); end
    reset = 1'b1;
    #1;
    total++; if (pop_vc0 !== 1'b0 || pop_vc1 !== 1'b0) begin bad++; $display("FAIL mrst_pop got=%b%b exp=00", pop_vc0, pop_vc1); end
    step();
    total++; if (valid_out !== 1'b0 || data_out !== 6'h00) begin bad++; $display("FAIL mrst_out got=%b/%h exp=0/00", valid_out, data_out); end
    total++; if (grants_vc0 !== 8'd0 || grants_vc1 !== 8'd0) begin bad++; $display("FAIL mrst_cnt got=%0d/%0d exp=0/0", grants_vc0, grants_vc1); end
    reset = 1'b0;
    #1;
  endtask

  task automatic test_zero_weights();
    do_reset();
    weight_vc0 = 3'd0; weight_vc1 = 3'd0;
    for (int i = 0; i < 4; i++) begin
      q0.push_back(6'(6'h08 + i)); q1.push_back(6'(6'h38 + i));
    end
    drive_fifos(); #1;
    run_order(4, 8'b0000_1010, "w00");
  endtask

  task automatic test_wrap();
    do_reset();
    weight_vc0 = 3'd7; weight_vc1 = 3'd0;
    for (int i = 0; i < 256; i++) q0.push_back(6'(i & 15));
    drive_fifos(); #1;
    for (int i = 0; i < 255; i++) step();
    total++; if (grants_vc0 !== 8'd255) begin bad++; $display("FAIL wrap_255 got=%0d exp=255", grants_vc0); end
    step();
    total++; if (grants_vc0 !== 8'd0) begin bad++; $display("FAIL wrap_0 got=%0d exp=0", grants_vc0); end
    total++; if (grants_vc1 !== 8'd0) begin bad++; $display("FAIL wrap_vc1 got=%0d exp=0", grants_vc1); end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1;
    weight_vc0 = 3'd1; weight_vc1 = 3'd1;
    man_d0_pause = 1'b0; man_d1_pause = 1'b0; auto_pause = 1'b0;
    d_cnt[0] = 0; d_cnt[1] = 0; d_max = 0;
    drive_fifos();
    test_reset();
    test_weights_3_1();
    test_work_conserving();
    test_backpressure();
    test_dfifo_margin();
    test_enable_drop();
    test_zero_weights();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
